sqrt_dispatch: RTL

- Job front-end that sits directly upstream of sqrt_calculator.
- Buffers incoming 17-bit radicands in a small FIFO and launches one square-root job at a time using sqrt_calculator's start/busy protocol.
- Captures each 9-bit root and presents it, together with its operand, on a valid/ready result port.
- Lets producers stream operands without tracking the calculator's variable latency.

---
 rtl/sqrt_dispatch.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/sqrt_dispatch.sv
// Operand FIFO and one-job-at-a-time launcher for sqrt_calculator. Head-to-start takes 2 cycles; throughput is one job per busy+3 cycles.
// Backpressure: req_ready_o drops when the FIFO is full; a launch waits until the result slot is free or being consumed.

module sqrt_dispatch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 17
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

module sqrt_dispatch #(
  parameter int DEPTH = 4,
  parameter int A_W   = 17,
  parameter int Y_W   = 9
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  input  logic [A_W-1:0]         req_data_bi,
  output logic                   req_ready_o,
  output logic [A_W-1:0]         sqrt_a_bo,
  output logic                   sqrt_start_o,
  input  logic                   sqrt_busy_i,
  input  logic [Y_W-1:0]         sqrt_y_bi,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic [Y_W-1:0]         res_y_bo,
  output logic [A_W-1:0]         res_a_bo,
  output logic [$clog2(DEPTH):0] pending_o
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, START, ARM, RUN} state_t;

  state_t         state;
  logic [A_W-1:0] op;
  logic           err_sticky;
  logic           push;
  logic           launch;
  logic           res_take;
  logic           fifo_empty;
  logic [CW-1:0]  count;
  logic [CW-1:0]  count_next;
  logic [A_W-1:0] head;

  assign push       = req_valid_i & req_ready_o;
  assign res_take   = res_valid_o & res_ready_i;
  assign launch     = (state == IDLE) & ~fifo_empty & (~res_valid_o | res_ready_i) & ~sqrt_busy_i;
  assign count_next = count + CW'(push) - CW'(launch);
  assign pending_o  = count + CW'(state != IDLE);

  sqrt_dispatch_fifo #(.DEPTH(DEPTH), .W(A_W)) u_fifo (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .push      (push),
    .push_data (req_data_bi),
    .pop       (launch),
    .head      (head),
    .count     (count),
    .empty     (fifo_empty)
  );

  // Registered from the next occupancy: low through reset, high one cycle after release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) req_ready_o <= 1'b0;
    else         req_ready_o <= (count_next != CW'(DEPTH));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      op           <= '0;
      sqrt_a_bo    <= '0;
      sqrt_start_o <= 1'b0;
      res_valid_o  <= 1'b0;
      res_y_bo     <= '0;
      res_a_bo     <= '0;
      err_sticky   <= 1'b0;
    end else begin
      sqrt_start_o <= 1'b0;
      if (res_take) res_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            op           <= head;
            sqrt_a_bo    <= head;
            sqrt_start_o <= 1'b1;
            state        <= START;
          end
        end
        START: state <= ARM;
        ARM: begin
          // A calculator that never raised busy has dropped the job.
          if (sqrt_busy_i) begin
            state <= RUN;
          end else begin
            err_sticky <= 1'b1;
            state      <= IDLE;
          end
        end
        RUN: begin
          if (!sqrt_busy_i) begin
            res_y_bo    <= sqrt_y_bi;
            res_a_bo    <= op;
            res_valid_o <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
